// File: rtl/uart_frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_rx_pkg
// Brief    : Shared state/error encodings and helpers for the UART frame
//            receiver (SYNC, CMD, LEN, payload, CHK framing).
// Revision : 1.0 - initial release
// ============================================================================
package uart_frame_rx_pkg;

  // Parser states, one per framing field plus the delivery phase.
  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_CMD  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_OUT  = 3'd5
  } state_e;

  // Reasons a frame is dropped; reported on err_code.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Bits needed to index 0..depth-1, never less than one.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_rx_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf
// Brief    : Payload buffer: DEPTH x 8 register file, one synchronous write
//            port and one asynchronous read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buf
  import uart_frame_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = idx_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Store one payload byte per write strobe.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_rx
// Brief    : Pops bytes from a first-word-fall-through UART RX FIFO, parses
//            SYNC/CMD/LEN/payload/CHK frames, buffers the payload and
//            forwards only checksum-clean payloads on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       receivable,
  input  logic [7:0] recv_data,
  output logic       recv_flag,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] out_cmd,
  output logic       out_last,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic [7:0] err_count
);

  localparam int unsigned IW        = idx_width(MAX_LEN);
  localparam int unsigned TW        = idx_width(TIMEOUT_CYCLES);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q,     state_d;
  logic          recv_flag_q, recv_flag_d;
  logic [7:0]    out_cmd_q,   out_cmd_d;
  logic [7:0]    len_q,       len_d;
  logic [7:0]    chk_q,       chk_d;
  logic [IW-1:0] wr_idx_q,    wr_idx_d;
  logic [IW-1:0] rd_idx_q,    rd_idx_d;
  logic [TW-1:0] tmo_q,       tmo_d;
  logic          err_pulse_q, err_pulse_d;
  err_e          err_code_q,  err_code_d;
  logic [7:0]    err_count_q, err_count_d;

  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic          err_hit;
  err_e          err_hit_code;

  // A byte is taken only on a fresh pulse: the FIFO head is stale for one
  // cycle after recv_flag, and intake is frozen while delivering a payload.
  logic pop;
  assign pop = receivable && !recv_flag_q && (state_q != ST_OUT);

  // Timeout only applies while a frame is partially received, and a byte
  // arriving on the same edge always wins over the timeout.
  logic in_frame;
  logic tmo_hit;
  assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                    (state_q == ST_DATA) || (state_q == ST_CHK);
  assign tmo_hit  = in_frame && !pop && (tmo_q == TMO_LAST);

  frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IW)
  ) u_frame_buf (
    .clk_i   (CLK),
    .we_i    (buf_we),
    .waddr_i (wr_idx_q),
    .wdata_i (recv_data),
    .raddr_i (rd_idx_q),
    .rdata_o (buf_rdata)
  );

  // State register and all datapath registers, asynchronously reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_SYNC;
      recv_flag_q <= 1'b0;
      out_cmd_q   <= 8'd0;
      len_q       <= 8'd0;
      chk_q       <= 8'd0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      tmo_q       <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      recv_flag_q <= recv_flag_d;
      out_cmd_q   <= out_cmd_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      tmo_q       <= tmo_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  // Frame parser: next state, checksum, indices, timeout and error reporting.
  always_comb begin
    state_d      = state_q;
    recv_flag_d  = pop;
    out_cmd_d    = out_cmd_q;
    len_d        = len_q;
    chk_d        = chk_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    tmo_d        = '0;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    err_count_d  = err_count_q;
    buf_we       = 1'b0;
    err_hit      = 1'b0;
    err_hit_code = ERR_NONE;

    if (in_frame && !pop) begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      ST_SYNC: begin
        if (pop && (recv_data == SYNC_BYTE)) begin
          chk_d   = 8'd0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (pop) begin
          out_cmd_d = recv_data;
          chk_d     = recv_data;
          state_d   = ST_LEN;
        end
      end
      ST_LEN: begin
        if (pop) begin
          if ((recv_data == 8'd0) || (recv_data > MAX_LEN_B)) begin
            err_hit      = 1'b1;
            err_hit_code = ERR_LEN;
            state_d      = ST_SYNC;
          end else begin
            len_d    = recv_data;
            chk_d    = chk_q ^ recv_data;
            wr_idx_d = '0;
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (pop) begin
          buf_we   = 1'b1;
          chk_d    = chk_q ^ recv_data;
          wr_idx_d = wr_idx_q + IW'(1);
          if (8'(wr_idx_q) == (len_q - 8'd1)) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (pop) begin
          if (recv_data == chk_q) begin
            rd_idx_d = '0;
            state_d  = ST_OUT;
          end else begin
            err_hit      = 1'b1;
            err_hit_code = ERR_CHK;
            state_d      = ST_SYNC;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (out_last) begin
            state_d = ST_SYNC;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase

    if (tmo_hit) begin
      err_hit      = 1'b1;
      err_hit_code = ERR_TIMEOUT;
      state_d      = ST_SYNC;
    end

    if (err_hit) begin
      err_pulse_d = 1'b1;
      err_code_d  = err_hit_code;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  assign recv_flag = recv_flag_q;
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_valid ? buf_rdata : 8'd0;
  assign out_last  = out_valid && (8'(rd_idx_q) == (len_q - 8'd1));
  assign out_cmd   = out_cmd_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_rx
// Brief    : Self-checking bench for uart_frame_rx. A queue models the FWFT
//            UART FIFO; expected payloads and errors come from a plain
//            sequential parse of the byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_rx;

  localparam int MAXL = 16;
  localparam int TMO  = 50;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       receivable = 1'b0;
  logic [7:0] recv_data = 8'd0;
  logic       out_ready = 1'b0;
  logic       recv_flag, out_valid, out_last, err_pulse;
  logic [7:0] out_data, out_cmd, err_count;
  logic [1:0] err_code;

  always #5 CLK = ~CLK;

  uart_frame_rx #(
    .MAX_LEN        (MAXL),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .receivable (receivable),
    .recv_data  (recv_data),
    .recv_flag  (recv_flag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cmd    (out_cmd),
    .out_last   (out_last),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .err_count  (err_count)
  );

  int checks = 0, errors = 0;
  int cyc = 0, last_cap = 0, caps = 0, pulses = 0, exp_pulses = 0;
  int rdy_mode = 0, pat = 0;
  bit chk_hold = 1'b0;
  int exp_cnt = 0;
  logic [1:0] exp_code = 2'd0;

  logic [7:0] fifo_q[$];
  logic [7:0] stim[$];
  logic [7:0] got_data[$], got_cmd[$], exp_data[$], exp_cmd[$];
  bit         got_last[$], exp_last[$];

  task automatic upd_fifo();
    receivable = (fifo_q.size() > 0);
    recv_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'd0;
  endtask

  // One clock: FIFO pops on recv_flag, consumer transfers are recorded.
  task automatic tick();
    bit fl, pv, pr, pl;
    logic [7:0] pd, pc;
    fl = recv_flag; pv = out_valid; pr = out_ready;
    pd = out_data;  pl = out_last;  pc = out_cmd;
    @(posedge CLK); #1;
    cyc++;
    if (fl && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (pv && pr) begin
      got_data.push_back(pd); got_last.push_back(pl); got_cmd.push_back(pc);
    end
    if (!fl && recv_flag) begin caps++; last_cap = cyc; end
    if (err_pulse) pulses++;
    if (chk_hold && pv && !pr) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
        errors++;
        $display("FAIL hold: got v=%b d=%h l=%b need v=1 d=%h l=%b",
                 out_valid, out_data, out_last, pd, pl);
      end
    end
    if (chk_hold && pv) begin
      checks++;
      if ((!fl && recv_flag) !== 1'b0) begin
        errors++;
        $display("FAIL no_pop_in_out: got new recv_flag pulse need none (receivable=%b)", receivable);
      end
    end
    upd_fifo();
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    pat++;
  endtask

  task automatic model_err(input logic [1:0] code);
    exp_cnt  = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    exp_code = code;
    exp_pulses++;
  endtask

  // Reference parse of a complete byte stream into payloads and errors.
  task automatic model(input logic [7:0] s[$]);
    int i, len;
    logic [7:0] cmd, x;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin i++; continue; end
      if (i + 2 >= s.size()) break;
      cmd = s[i+1]; len = int'(s[i+2]); i += 3;
      if (len == 0 || len > MAXL) begin model_err(2'd1); continue; end
      x = cmd ^ 8'(len);
      for (int k = 0; k < len; k++) x ^= s[i+k];
      if (s[i+len] == x) begin
        for (int k = 0; k < len; k++) begin
          exp_data.push_back(s[i+k]); exp_last.push_back(k == len - 1); exp_cmd.push_back(cmd);
        end
      end else begin
        model_err(2'd2);
      end
      i += len + 1;
    end
  endtask

  task automatic add_frame(input logic [7:0] cmd, input int len, input bit bad);
    logic [7:0] x, b;
    stim.push_back(8'hA5); stim.push_back(cmd); stim.push_back(8'(len));
    x = cmd ^ 8'(len);
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255)); x ^= b; stim.push_back(b);
    end
    stim.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  task automatic send();
    model(stim);
    foreach (stim[i]) fifo_q.push_back(stim[i]);
    stim.delete();
    upd_fifo();
  endtask

  task automatic new_test();
    got_data.delete(); got_last.delete(); got_cmd.delete();
    exp_data.delete(); exp_last.delete(); exp_cmd.delete();
    pulses = 0; exp_pulses = 0;
  endtask

  function automatic int first_diff();
    if (got_data.size() != exp_data.size()) return -2;
    foreach (got_data[i])
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_cmd[i] !== exp_cmd[i])
        return i;
    return -1;
  endfunction

  task automatic run_idle();
    int idle, n;
    idle = 0; n = 0;
    while (idle < 4 && n < 6000) begin
      tick(); n++;
      if (fifo_q.size() == 0 && !recv_flag && !out_valid) idle++; else idle = 0;
    end
    checks++;
    if (idle < 4) begin
      errors++;
      $display("FAIL drain_timeout: got %0d fifo bytes left need 0", fifo_q.size());
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick(); tick();
    checks++;
    if ({recv_flag, out_valid, out_data, out_cmd, out_last, err_pulse, err_code, err_count} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got flag=%b v=%b d=%h cmd=%h l=%b p=%b code=%0d cnt=%0d need all 0",
               recv_flag, out_valid, out_data, out_cmd, out_last, err_pulse, err_code, err_count);
    end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    new_test();
    stim = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
    send(); run_idle();
    checks++;
    if (first_diff() !== -1) begin errors++; $display("FAIL good_stream: got diff=%0d n=%0d need diff=-1 n=%0d", first_diff(), got_data.size(), exp_data.size()); end
    checks++;
    if (got_data.size() !== 2 || got_data[0] !== 8'h11 || got_data[1] !== 8'h22 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
      errors++; $display("FAIL good_bytes: got n=%0d need 11,22 with last on 22", got_data.size());
    end
    checks++;
    if (out_cmd !== 8'h01) begin errors++; $display("FAIL good_cmd: got %h need 01", out_cmd); end
    checks++;
    if (pulses !== 0 || err_count !== 8'd0) begin errors++; $display("FAIL good_noerr: got pulses=%0d cnt=%0d need 0,0", pulses, err_count); end
  endtask

  task automatic test_bad_chk();
    new_test();
    stim = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h31, 8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
    send(); run_idle();
    checks++;
    if (first_diff() !== -1) begin errors++; $display("FAIL badchk_stream: got diff=%0d n=%0d need diff=-1 n=%0d", first_diff(), got_data.size(), exp_data.size()); end
    checks++;
    if (pulses !== exp_pulses) begin errors++; $display("FAIL badchk_pulses: got %0d need %0d", pulses, exp_pulses); end
    checks++;
    if (err_code !== 2'd2 || err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL badchk_code: got code=%0d cnt=%0d need 2,%0d", err_code, err_count, exp_cnt); end
  endtask

  task automatic test_bad_len();
    new_test();
    stim = '{8'hA5, 8'h07, 8'h00, 8'hA5, 8'h07, 8'h11};
    send(); run_idle();
    checks++;
    if (got_data.size() !== 0) begin errors++; $display("FAIL badlen_out: got %0d bytes need 0", got_data.size()); end
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL badlen_pulses: got %0d need 2", pulses); end
    checks++;
    if (err_code !== exp_code || err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL badlen_code: got code=%0d cnt=%0d need %0d,%0d", err_code, err_count, exp_code, exp_cnt); end
  endtask

  task automatic test_timeout();
    int n, hit;
    new_test();
    fifo_q = '{8'hA5, 8'h01, 8'h03, 8'hAA};
    upd_fifo();
    n = 0;
    while ((fifo_q.size() != 0 || recv_flag) && n < 100) begin tick(); n++; end
    hit = -1; n = 0;
    while (hit < 0 && n < 3 * TMO) begin
      tick(); n++;
      if (err_pulse) hit = cyc;
    end
    model_err(2'd3);
    checks++;
    if (hit - last_cap !== TMO) begin errors++; $display("FAIL timeout_latency: got %0d idle cycles need %0d", hit - last_cap, TMO); end
    checks++;
    if (err_code !== 2'd3 || err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL timeout_code: got code=%0d cnt=%0d need 3,%0d", err_code, err_count, exp_cnt); end
    add_frame(8'h3C, 5, 1'b0);
    send(); run_idle();
    checks++;
    if (first_diff() !== -1 || pulses !== exp_pulses) begin errors++; $display("FAIL timeout_resync: got diff=%0d pulses=%0d need -1,%0d", first_diff(), pulses, exp_pulses); end
  endtask

  task automatic test_backpressure();
    new_test();
    rdy_mode = 1; pat = 0; chk_hold = 1'b1;
    add_frame(8'h42, 4, 1'b0);
    add_frame(8'h43, 3, 1'b0);
    send(); run_idle();
    chk_hold = 1'b0; rdy_mode = 0;
    checks++;
    if (first_diff() !== -1) begin errors++; $display("FAIL bp_stream: got diff=%0d n=%0d need diff=-1 n=%0d", first_diff(), got_data.size(), exp_data.size()); end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL bp_noerr: got %0d pulses need 0", pulses); end
  endtask

  task automatic test_reset_mid();
    int n;
    new_test();
    add_frame(8'h5C, 6, 1'b0);
    foreach (stim[i]) fifo_q.push_back(stim[i]);
    stim.delete(); upd_fifo();
    caps = 0; n = 0;
    while (caps < 5 && n < 100) begin tick(); n++; end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({recv_flag, out_valid, out_data, out_cmd, out_last, err_pulse, err_code, err_count} !== 30'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got flag=%b v=%b cmd=%h code=%0d cnt=%0d need all 0",
               recv_flag, out_valid, out_cmd, err_code, err_count);
    end
    fifo_q.delete(); upd_fifo();
    tick(); tick();
    RST = 1'b1;
    exp_cnt = 0; exp_code = 2'd0;
    new_test();
    stim = '{8'h00, 8'hFF, 8'h13};
    add_frame(8'h77, 3, 1'b0);
    send(); run_idle();
    checks++;
    if (first_diff() !== -1) begin errors++; $display("FAIL junk_stream: got diff=%0d n=%0d need diff=-1 n=%0d", first_diff(), got_data.size(), exp_data.size()); end
    checks++;
    if (pulses !== 0 || err_count !== 8'd0) begin errors++; $display("FAIL junk_noerr: got pulses=%0d cnt=%0d need 0,0", pulses, err_count); end
  endtask

  task automatic test_random();
    int r;
    new_test();
    rdy_mode = 2; chk_hold = 1'b1;
    for (int f = 0; f < 24; f++) begin
      r = $urandom_range(0, 9);
      if (r < 5) add_frame(8'($urandom), $urandom_range(1, MAXL), 1'b0);
      else if (r < 7) add_frame(8'($urandom), $urandom_range(1, MAXL), 1'b1);
      else if (r == 7) begin
        stim.push_back(8'hA5); stim.push_back(8'($urandom));
        stim.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
      end else begin
        for (int j = 0; j < $urandom_range(1, 3); j++) stim.push_back(8'($urandom_range(0, 8'hA4)));
      end
    end
    send(); run_idle();
    chk_hold = 1'b0; rdy_mode = 0;
    checks++;
    if (first_diff() !== -1) begin errors++; $display("FAIL rand_stream: got diff=%0d n=%0d need diff=-1 n=%0d", first_diff(), got_data.size(), exp_data.size()); end
    checks++;
    if (pulses !== exp_pulses || err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL rand_errs: got pulses=%0d cnt=%0d need %0d,%0d", pulses, err_count, exp_pulses, exp_cnt); end
    checks++;
    if (exp_pulses > 0 && err_code !== exp_code) begin errors++; $display("FAIL rand_code: got %0d need %0d", err_code, exp_code); end
  endtask

  task automatic test_saturation();
    new_test();
    for (int f = 0; f < 300; f++) begin
      stim.push_back(8'hA5); stim.push_back(8'($urandom)); stim.push_back(8'h00);
    end
    send(); run_idle();
    checks++;
    if (err_count !== 8'hFF || exp_cnt != 255) begin errors++; $display("FAIL saturation: got cnt=%0d need 255", err_count); end
    checks++;
    if (pulses !== 300) begin errors++; $display("FAIL sat_pulses: got %0d need 300", pulses); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
